async_tx: RTL and testbench

ASYNC_TX -- requirements
Module: async_tx

---
 rtl/async_tx.sv | 54 +++++
 tb/tb_async_tx.sv | 115 +++++++++++
 2 files changed

// File: rtl/async_tx.sv
// async_tx: coalescing, gap-limited writer of duty-cycle values into an async FIFO.
module async_tx #(
  parameter int WIDTH   = 12,
  parameter int MIN_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             full,
  output logic             w_en,
  output logic [WIDTH-1:0] data,
  output logic             pending,
  output logic [7:0]       coalesce_cnt
);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  typedef enum logic {IDLE, PEND} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_last;
  logic [GW-1:0]    r_gap;
  logic [7:0]       r_coal;
  logic             w_gap_done;
  assign w_gap_done   = (r_gap == '0);
  assign w_en         = (r_state == PEND) & ~full & w_gap_done;
  assign data         = r_hold;
  assign pending      = (r_state == PEND);
  assign coalesce_cnt = r_coal;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_last  <= '0;
      r_gap   <= '0;
      r_coal  <= '0;
    end else begin
      r_gap <= w_en ? GW'(MIN_GAP - 1) : (w_gap_done ? r_gap : r_gap - 1'b1);
      if (r_state == IDLE) begin
        // Strobes repeating the last written value carry no news for the receiver.
        if (wr_valid && wr_data != r_last) begin
          r_hold  <= wr_data;
          r_state <= PEND;
        end
      end else if (w_en) begin
        r_last <= r_hold;
        if (wr_valid) r_hold <= wr_data;
        else r_state <= IDLE;
      end else if (wr_valid) begin
        r_hold <= wr_data;
        r_coal <= r_coal + {7'd0, r_coal != 8'hFF};
      end
    end
  end
endmodule

// File: tb/tb_async_tx.sv
// tb_async_tx: directed checks of async_tx with MIN_GAP=4 and MIN_GAP=1 instances.
module tb_async_tx;
  logic        clk = 0;
  logic        rst = 1;
  logic        a_valid = 0, b_valid = 0;
  logic [11:0] a_wdata = 0, b_wdata = 0;
  logic        a_full = 0, b_full = 0;
  logic        a_wen, b_wen, a_pend, b_pend;
  logic [11:0] a_data, b_data;
  logic [7:0]  a_coal, b_coal;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  async_tx #(.WIDTH(12), .MIN_GAP(4)) u_a (
    .clk(clk), .rst(rst), .wr_valid(a_valid), .wr_data(a_wdata), .full(a_full),
    .w_en(a_wen), .data(a_data), .pending(a_pend), .coalesce_cnt(a_coal));
  async_tx #(.WIDTH(12), .MIN_GAP(1)) u_b (
    .clk(clk), .rst(rst), .wr_valid(b_valid), .wr_data(b_wdata), .full(b_full),
    .w_en(b_wen), .data(b_data), .pending(b_pend), .coalesce_cnt(b_coal));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int seen;
    logic [11:0] last_v;
    tick(2);
    rst = 0;
    #1;
    check("rst_wen", a_wen, 0);
    check("rst_data", a_data, 0);
    check("rst_pend", a_pend, 0);
    check("rst_coal", a_coal, 0);
    // MIN_GAP=1: back-to-back writes
    b_valid = 1; b_wdata = 12'd5; tick();
    b_wdata = 12'd6; #1;
    check("g1_wen0", b_wen, 1); check("g1_data0", b_data, 5); tick();
    b_wdata = 12'd7; #1;
    check("g1_wen1", b_wen, 1); check("g1_data1", b_data, 6); tick();
    b_valid = 0; #1;
    check("g1_wen2", b_wen, 1); check("g1_data2", b_data, 7); tick();
    check("g1_idle", b_wen, 0); check("g1_pend", b_pend, 0);
    // zero strobe after reset is suppressed
    a_valid = 1; a_wdata = 12'h000; tick();
    a_valid = 0; #1;
    check("zero_pend", a_pend, 0); check("zero_wen", a_wen, 0);
    // single write, latency 1
    a_valid = 1; a_wdata = 12'h3A5; #1;
    check("sw_wen_n", a_wen, 0); tick();
    a_valid = 0; #1;
    check("sw_wen_n1", a_wen, 1); check("sw_data_n1", a_data, 12'h3A5); tick();
    check("sw_wen_n2", a_wen, 0); check("sw_pend_n2", a_pend, 0);
    // duplicate suppressed
    a_valid = 1; a_wdata = 12'h3A5; tick();
    a_valid = 0; #1;
    check("dup_pend", a_pend, 0); check("dup_wen", a_wen, 0);
    tick(4);
    // gap and coalesce
    a_valid = 1; a_wdata = 12'd1; tick();
    a_wdata = 12'd2; #1;
    check("gc_wen1", a_wen, 1); check("gc_data1", a_data, 1); tick();
    a_wdata = 12'd3; #1;
    check("gc_wen2", a_wen, 0); check("gc_data2", a_data, 2); tick();
    a_valid = 0; #1;
    check("gc_coal", a_coal, 1); check("gc_data3", a_data, 3); check("gc_wen3", a_wen, 0); tick();
    check("gc_wen4", a_wen, 0); tick();
    check("gc_wen5", a_wen, 1); check("gc_data5", a_data, 3); tick();
    check("gc_pend6", a_pend, 0);
    tick(4);
    // full backpressure with saturating coalesce count
    a_full = 1; a_valid = 1; a_wdata = 12'h100; tick();
    check("bp_pend", a_pend, 1);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      last_v = 12'h200 + 12'(i);
      a_wdata = last_v; #1;
      if (a_wen) seen++;
      tick();
    end
    a_valid = 0; #1;
    check("bp_wen_seen", seen, 0);
    check("bp_coal_sat", a_coal, 255);
    check("bp_data", a_data, last_v);
    a_full = 0; #1;
    check("bp_release_wen", a_wen, 1); check("bp_release_data", a_data, last_v);
    tick();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_wen) seen++;
      tick();
    end
    check("bp_once", seen, 0); check("bp_pend_end", a_pend, 0);
    // reset mid-operation discards the held value
    a_full = 1; a_valid = 1; a_wdata = 12'h555; tick();
    check("mr_pend", a_pend, 1);
    rst = 1; a_wdata = 12'h666; tick();
    rst = 0; a_valid = 0; a_full = 0; #1;
    check("mr_pend0", a_pend, 0); check("mr_wen0", a_wen, 0);
    check("mr_coal0", a_coal, 0); check("mr_data0", a_data, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_wen) seen++;
      tick();
    end
    check("mr_never", seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
